// File: rtl/axis_matvec_coproc_if.sv
// AXI-Stream link used on both sides of the matrix-vector coprocessor.
// The master drives TVALID/TDATA/TLAST; the slave drives TREADY.
interface axis_matvec_coproc_if;
    logic        TVALID;
    logic        TREADY;
    logic [31:0] TDATA;
    logic        TLAST;

    modport master (output TVALID, output TDATA, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);
endinterface

// File: rtl/axis_matvec_coproc.sv
// Streams in matrix A and vector B, computes sat((A*B) >> SHIFT) per row, and streams out A_ROWS results.
// Define MATVEC_TLAST_CHECK_EN to abort a frame on an early S_AXIS TLAST.
module axis_matvec_coproc #(
    parameter int A_ROWS = 64,
    parameter int A_COLS = 8,
    parameter int WIDTH  = 8,
    parameter int SHIFT  = 8
) (
    input  logic ACLK,
    input  logic ARESETN,
    axis_matvec_coproc_if.slave  S_AXIS,
    axis_matvec_coproc_if.master M_AXIS
);
    localparam int A_N   = A_ROWS * A_COLS;
    localparam int IN_N  = A_N + A_COLS;
    localparam int CW    = $clog2(IN_N + 1);
    localparam int AAW   = (A_N > 1) ? $clog2(A_N) : 1;
    localparam int BAW   = (A_COLS > 1) ? $clog2(A_COLS) : 1;
    localparam int RAW   = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
    localparam int KW    = $clog2(A_COLS + 1);
    localparam int ACC_W = 2 * WIDTH + $clog2(A_COLS);

    localparam logic [CW-1:0]  IN_LAST  = CW'(IN_N - 1);
    localparam logic [CW-1:0]  A_END    = CW'(A_N);
    localparam logic [RAW-1:0] ROW_LAST = RAW'(A_ROWS - 1);
    localparam logic [KW-1:0]  COL_WB   = KW'(A_COLS);

    typedef enum logic [1:0] {IDLE, READ, COMPUTE, WRITE} state_t;

    function automatic logic [WIDTH-1:0] sat_shift(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] sh;
        sh = acc >> SHIFT;
        if (|sh[ACC_W-1:WIDTH]) return {WIDTH{1'b1}};
        return sh[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] a_ram   [A_N];
    logic [WIDTH-1:0] b_ram   [A_COLS];
    logic [WIDTH-1:0] res_ram [A_ROWS];

    state_t           state_q,    state_d;
    logic [CW-1:0]    in_cnt_q,   in_cnt_d;
    logic             s_tready_q, s_tready_d;
    logic [RAW-1:0]   row_q,      row_d;
    logic [KW-1:0]    col_q,      col_d;
    logic [AAW-1:0]   mac_addr_q, mac_addr_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic [RAW-1:0]   out_idx_q,  out_idx_d;
    logic             m_tvalid_q, m_tvalid_d;
    logic [WIDTH-1:0] m_tdata_q,  m_tdata_d;
    logic             m_tlast_q,  m_tlast_d;

    logic             s_hs, m_hs;
    logic             a_we, b_we, res_we;
    logic [AAW-1:0]   a_wr_idx;
    logic [BAW-1:0]   b_wr_idx;
    logic [WIDTH-1:0] a_rd, b_rd;
    logic [WIDTH-1:0] res_wr_val, res_rd_val;
    logic [RAW-1:0]   res_rd_idx;
    logic             unused_ok;

    assign s_hs = s_tready_q & S_AXIS.TVALID;
    assign m_hs = m_tvalid_q & M_AXIS.TREADY;

    assign a_we     = s_hs && (state_q == READ) && (in_cnt_q < A_END);
    assign b_we     = s_hs && (state_q == READ) && (in_cnt_q >= A_END);
    assign a_wr_idx = in_cnt_q[AAW-1:0];
    assign b_wr_idx = BAW'(in_cnt_q - A_END);

    assign a_rd = a_ram[mac_addr_q];
    assign b_rd = b_ram[col_q[BAW-1:0]];

    assign res_we     = (state_q == COMPUTE) && (col_q == COL_WB);
    assign res_wr_val = sat_shift(acc_q);
    // Next word to present; bypass covers the last row landing in the same cycle it is read.
    assign res_rd_idx = (state_q == WRITE) ? RAW'(out_idx_q + 1'b1) : '0;
    assign res_rd_val = (res_we && (row_q == res_rd_idx)) ? res_wr_val : res_ram[res_rd_idx];

    assign unused_ok = ^{S_AXIS.TDATA[31:WIDTH], S_AXIS.TLAST};

    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        s_tready_d = s_tready_q;
        row_d      = row_q;
        col_d      = col_q;
        mac_addr_d = mac_addr_q;
        acc_d      = acc_q;
        out_idx_d  = out_idx_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;

        case (state_q)
            IDLE: begin
                state_d    = READ;
                s_tready_d = 1'b1;
            end
            READ: begin
                if (s_hs) begin
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d   = '0;
                        s_tready_d = 1'b0;
                        row_d      = '0;
                        col_d      = '0;
                        mac_addr_d = '0;
                        state_d    = COMPUTE;
                    end
`ifdef MATVEC_TLAST_CHECK_EN
                    else if (S_AXIS.TLAST) begin
                        in_cnt_d = '0;
                    end
`endif
                    else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                // Column A_COLS is the writeback slot; column 0 restarts the accumulator.
                if (col_q == COL_WB) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d      = '0;
                        mac_addr_d = '0;
                        out_idx_d  = '0;
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = res_rd_val;
                        m_tlast_d  = (ROW_LAST == '0);
                        state_d    = WRITE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    acc_d      = ((col_q == '0) ? ACC_W'(0) : acc_q) + ACC_W'(a_rd) * ACC_W'(b_rd);
                    col_d      = col_q + 1'b1;
                    mac_addr_d = mac_addr_q + 1'b1;
                end
            end
            WRITE: begin
                if (m_hs) begin
                    if (out_idx_q == ROW_LAST) begin
                        out_idx_d  = '0;
                        m_tvalid_d = 1'b0;
                        m_tdata_d  = '0;
                        m_tlast_d  = 1'b0;
                        s_tready_d = 1'b1;
                        state_d    = READ;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                        m_tdata_d = res_rd_val;
                        m_tlast_d = (RAW'(out_idx_q + 1'b1) == ROW_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            in_cnt_q   <= '0;
            s_tready_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            mac_addr_q <= '0;
            out_idx_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            s_tready_q <= s_tready_d;
            row_q      <= row_d;
            col_q      <= col_d;
            mac_addr_q <= mac_addr_d;
            out_idx_q  <= out_idx_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    // Storage and accumulator carry no reset; their contents are rebuilt every frame.
    always_ff @(posedge ACLK) begin
        acc_q <= acc_d;
        if (a_we)   a_ram[a_wr_idx] <= S_AXIS.TDATA[WIDTH-1:0];
        if (b_we)   b_ram[b_wr_idx] <= S_AXIS.TDATA[WIDTH-1:0];
        if (res_we) res_ram[row_q]  <= res_wr_val;
    end

    assign S_AXIS.TREADY = s_tready_q;
    assign M_AXIS.TVALID = m_tvalid_q;
    assign M_AXIS.TDATA  = {{(32-WIDTH){1'b0}}, m_tdata_q};
    assign M_AXIS.TLAST  = m_tlast_q;
endmodule

// File: tb/tb_axis_matvec_coproc.sv
// Bench for axis_matvec_coproc: random and directed frames against a frame-level reference model.
module tb_axis_matvec_coproc;
    localparam int A_ROWS = 64;
    localparam int A_COLS = 8;
    localparam int WIDTH  = 8;
    localparam int SHIFT  = 8;
    localparam int A_N    = A_ROWS * A_COLS;
    localparam int IN_N   = A_N + A_COLS;
    localparam int TO     = 20000;
`ifdef MATVEC_TLAST_CHECK_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_matvec_coproc_if s_if();
    axis_matvec_coproc_if m_if();

    axis_matvec_coproc #(.A_ROWS(A_ROWS), .A_COLS(A_COLS), .WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
        .ACLK(clk), .ARESETN(rst_n), .S_AXIS(s_if.slave), .M_AXIS(m_if.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    int unsigned stim_d[$];
    bit          stim_l[$];
    int unsigned exp_d[$];
    bit          exp_l[$];
    int unsigned got_d[$];
    int          hs_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: collect words (discarding on early TLAST when enabled), then dot products.
    task automatic build_expected();
        int unsigned frame[$];
        longint unsigned sum;
        exp_d.delete();
        exp_l.delete();
        foreach (stim_d[i]) begin
            if (TLAST_EN && stim_l[i] && frame.size() != IN_N - 1) begin
                frame.delete();
                continue;
            end
            frame.push_back(stim_d[i] & ((1 << WIDTH) - 1));
            if (frame.size() == IN_N) begin
                for (int r = 0; r < A_ROWS; r++) begin
                    sum = 0;
                    for (int c = 0; c < A_COLS; c++)
                        sum += longint'(frame[r*A_COLS+c]) * longint'(frame[A_N+c]);
                    sum = sum >> SHIFT;
                    if (sum > (1 << WIDTH) - 1) sum = (1 << WIDTH) - 1;
                    exp_d.push_back(32'(sum));
                    exp_l.push_back(r == A_ROWS - 1);
                end
                frame.delete();
            end
        end
    endtask

    // kind 0: A=r+c, B=c+1; 1: all 255; 2: A=0, B random; 3: random 32-bit words
    task automatic add_frame(input int kind);
        int v;
        for (int k = 0; k < IN_N; k++) begin
            case (kind)
                0:       v = (k < A_N) ? (k / A_COLS + k % A_COLS) : (k - A_N + 1);
                1:       v = 255;
                2:       v = (k < A_N) ? 0 : int'($urandom);
                default: v = int'($urandom);
            endcase
            stim_d.push_back(v);
            stim_l.push_back(k == IN_N - 1);
        end
    endtask

    task automatic send_stream(input int gmode);
        int n;
        int g;
        foreach (stim_d[i]) begin
            s_if.TVALID = 1'b1;
            s_if.TDATA  = stim_d[i];
            s_if.TLAST  = stim_l[i];
            n = 0;
            while (!s_if.TREADY && n < TO) begin
                @(negedge clk);
                n++;
            end
            if (n >= TO) begin
                check("send_timeout", i, stim_d.size());
                s_if.TVALID = 1'b0;
                return;
            end
            hs_cyc = cyc;
            @(negedge clk);
            case (gmode)
                1:       g = (i == 1) ? 2 : ((i == 200) ? 6 : 0);
                2:       g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                default: g = 0;
            endcase
            if (g > 0) begin
                s_if.TVALID = 1'b0;
                repeat (g) @(negedge clk);
            end
        end
        s_if.TVALID = 1'b0;
        s_if.TLAST  = 1'b0;
    endtask

    task automatic recv_stream(input int bmode, input bit lat_chk);
        int idx = 0;
        int t = 0;
        int k = 0;
        bit stall = 0;
        bit seen = 0;
        logic [31:0] hold_d = '0;
        logic        hold_l = 1'b0;
        got_d.delete();
        while (idx < exp_d.size() && t < TO) begin
            @(negedge clk);
            t++;
            case (bmode)
                1:       m_if.TREADY = (k % 3 == 0);
                2:       m_if.TREADY = 1'($urandom_range(0, 1));
                default: m_if.TREADY = 1'b1;
            endcase
            k++;
            if (m_if.TVALID) begin
                check("tready_tvalid_excl", 32'(s_if.TREADY), 0);
                if (!seen) begin
                    seen = 1;
                    if (lat_chk) check("first_tvalid_latency", cyc - hs_cyc, A_ROWS * (A_COLS + 1) + 1);
                end
                if (stall) begin
                    check("stall_hold_data", m_if.TDATA, hold_d);
                    check("stall_hold_last", 32'(m_if.TLAST), 32'(hold_l));
                end
                if (m_if.TREADY) begin
                    check("res_data", m_if.TDATA, exp_d[idx]);
                    check("res_last", 32'(m_if.TLAST), 32'(exp_l[idx]));
                    got_d.push_back(m_if.TDATA);
                    idx++;
                    stall = 0;
                end else begin
                    stall  = 1;
                    hold_d = m_if.TDATA;
                    hold_l = m_if.TLAST;
                end
            end
        end
        if (idx < exp_d.size()) begin
            check("recv_timeout", idx, exp_d.size());
        end else begin
            @(negedge clk);
            check("post_tvalid", 32'(m_if.TVALID), 0);
            check("post_tlast", 32'(m_if.TLAST), 0);
            check("post_read_tready", 32'(s_if.TREADY), 1);
        end
        m_if.TREADY = 1'b0;
    endtask

    task automatic run(input int gmode, input int bmode, input bit lat_chk);
        build_expected();
        fork
            send_stream(gmode);
            recv_stream(bmode, lat_chk);
        join
    endtask

    task automatic wait_tvalid();
        int n = 0;
        while (!m_if.TVALID && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_tvalid", 32'(m_if.TVALID), 1);
    endtask

    initial begin
        s_if.TVALID = 1'b0;
        s_if.TDATA  = '0;
        s_if.TLAST  = 1'b0;
        m_if.TREADY = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_tready", 32'(s_if.TREADY), 0);
        check("rst_m_tvalid", 32'(m_if.TVALID), 0);
        check("rst_m_tdata", m_if.TDATA, 0);
        check("rst_m_tlast", 32'(m_if.TLAST), 0);
        rst_n = 1'b1;
        #1 check("idle_tready", 32'(s_if.TREADY), 0);
        @(negedge clk);
        check("read_tready", 32'(s_if.TREADY), 1);

        // Basic frame with latency and known corner results
        stim_d.delete(); stim_l.delete(); add_frame(0);
        run(0, 0, 1);
        check("basic_count", got_d.size(), A_ROWS);
        if (got_d.size() > 0) check("basic_res0", got_d[0], 0);

        stim_d.delete(); stim_l.delete(); add_frame(0);
        run(1, 0, 0);
        stim_d.delete(); stim_l.delete(); add_frame(3);
        run(2, 1, 0);
        stim_d.delete(); stim_l.delete(); add_frame(1);
        run(0, 1, 0);
        if (got_d.size() == A_ROWS) check("sat_res_last", got_d[A_ROWS-1], 255);
        stim_d.delete(); stim_l.delete(); add_frame(2);
        run(2, 2, 0);
        stim_d.delete(); stim_l.delete(); add_frame(3); add_frame(3);
        run(2, 2, 0);

        // Early TLAST on word 100, then a full frame
        stim_d.delete(); stim_l.delete();
        for (int i = 0; i <= 100; i++) begin
            stim_d.push_back($urandom);
            stim_l.push_back(i == 100);
        end
        add_frame(0);
        if (!TLAST_EN) begin
            for (int i = 0; i < IN_N - 101; i++) begin
                stim_d.push_back(0);
                stim_l.push_back(i == IN_N - 102);
            end
        end
        run(0, 0, 0);

        // Async reset during COMPUTE
        stim_d.delete(); stim_l.delete(); add_frame(1);
        m_if.TREADY = 1'b0;
        send_stream(0);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_cmp_tready", 32'(s_if.TREADY), 0);
        check("rst_cmp_tvalid", 32'(m_if.TVALID), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Async reset while a result is stalled in WRITE
        send_stream(0);
        wait_tvalid();
        check("rst_wr_pre_tdata", m_if.TDATA, 255);
        #2 rst_n = 1'b0;
        #1 check("rst_wr_tvalid", 32'(m_if.TVALID), 0);
        check("rst_wr_tdata", m_if.TDATA, 0);
        check("rst_wr_tlast", 32'(m_if.TLAST), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        stim_d.delete(); stim_l.delete(); add_frame(0);
        run(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
